// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares one SDRAM slave between three burst requesters, port 0 fixed priority, ports 1/2 round-robin
module sdram_arbiter #(
    parameter int AW = 25,
    parameter int DW = 16,
    parameter int LW = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [2:0]      req,
    input  logic [2:0]      we,
    input  logic [3*AW-1:0] addr,
    input  logic [3*DW-1:0] wdata,
    input  logic [3*LW-1:0] len,
    output logic [2:0]      grant,
    output logic [2:0]      ack,
    output logic [2:0]      rvalid,
    output logic [DW-1:0]   rdata,
    output logic [2:0]      done,
    output logic [AW-1:0]   m_address,
    output logic            m_read,
    output logic            m_write,
    output logic [DW-1:0]   m_writedata,
    input  logic            m_waitrequest,
    input  logic [DW-1:0]   m_readdata,
    input  logic            m_readdatavalid
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
    state_t        state, state_nxt;
    logic [1:0]    owner, owner_nxt, win;
    logic [2:0]    grant_nxt, owner_oh;
    logic          wr, wr_nxt, rr_two, rr_two_nxt, read_nxt, write_nxt, accept, ret;
    logic [AW-1:0] address_nxt;
    logic [LW-1:0] blen, blen_nxt, win_len, icnt, icnt_nxt, rcnt, rcnt_nxt;

    // arbitration winner: port 0 first, otherwise the port of {1,2} not served last
    always_comb begin
        win     = req[0] ? 2'd0 : (req[1] && req[2]) ? (rr_two ? 2'd2 : 2'd1) : req[1] ? 2'd1 : 2'd2;
        win_len = len[int'(win)*LW +: LW] == '0 ? LW'(1) : len[int'(win)*LW +: LW];
    end

    assign owner_oh    = 3'b001 << owner;
    assign accept      = (m_read || m_write) && !m_waitrequest;
    assign ret         = m_readdatavalid && (state == ISSUE || state == DRAIN);
    assign ack         = (m_write && !m_waitrequest) ? owner_oh : 3'b000;
    assign rvalid      = ret ? owner_oh : 3'b000;
    assign done        = state == DONE ? owner_oh : 3'b000;
    assign rdata       = m_readdata;
    assign m_writedata = wdata[int'(owner)*DW +: DW];

    // next state plus next values of the burst context and the registered slave command
    always_comb begin
        state_nxt   = state;
        owner_nxt   = owner;
        grant_nxt   = grant;
        wr_nxt      = wr;
        address_nxt = m_address;
        blen_nxt    = blen;
        icnt_nxt    = icnt;
        rcnt_nxt    = (ret && rcnt != blen) ? rcnt + LW'(1) : rcnt;
        rr_two_nxt  = rr_two;
        read_nxt    = m_read;
        write_nxt   = m_write;
        case (state)
            IDLE: if (|req) begin
                state_nxt   = ISSUE;
                owner_nxt   = win;
                grant_nxt   = 3'b001 << win;
                wr_nxt      = we[win];
                address_nxt = addr[int'(win)*AW +: AW];
                blen_nxt    = win_len;
                icnt_nxt    = '0;
                rcnt_nxt    = '0;
                read_nxt    = !we[win];
                write_nxt   = we[win];
            end
            ISSUE: if (accept) begin
                icnt_nxt    = icnt + LW'(1);
                address_nxt = m_address + AW'(1);
                if (icnt == blen - LW'(1)) begin
                    read_nxt  = 1'b0;
                    write_nxt = 1'b0;
                    state_nxt = (wr || rcnt_nxt == blen) ? DONE : DRAIN;
                end
            end
            DRAIN: state_nxt = rcnt_nxt == blen ? DONE : DRAIN;
            DONE: begin
                state_nxt  = IDLE;
                grant_nxt  = 3'b000;
                rr_two_nxt = owner == 2'd1 ? 1'b1 : owner == 2'd2 ? 1'b0 : rr_two;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // state register and registered outputs; reset abandons any burst in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            owner     <= 2'd0;
            grant     <= 3'b000;
            wr        <= 1'b0;
            m_address <= '0;
            blen      <= LW'(1);
            icnt      <= '0;
            rcnt      <= '0;
            rr_two    <= 1'b0;
            m_read    <= 1'b0;
            m_write   <= 1'b0;
        end else begin
            state     <= state_nxt;
            owner     <= owner_nxt;
            grant     <= grant_nxt;
            wr        <= wr_nxt;
            m_address <= address_nxt;
            blen      <= blen_nxt;
            icnt      <= icnt_nxt;
            rcnt      <= rcnt_nxt;
            rr_two    <= rr_two_nxt;
            m_read    <= read_nxt;
            m_write   <= write_nxt;
        end
    end
endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed bench with a word-counting reference model and a latency slave for sdram_arbiter
module tb_sdram_arbiter;
    localparam int AW = 25;
    localparam int DW = 16;
    localparam int LW = 8;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [2:0]      req = '0, we = '0;
    logic [3*AW-1:0] addr = '0;
    logic [3*DW-1:0] wdata = '0;
    logic [3*LW-1:0] len = '0;
    logic [2:0]      grant, ack, rvalid, done;
    logic [DW-1:0]   rdata, m_writedata;
    logic [AW-1:0]   m_address;
    logic            m_read, m_write;
    logic            m_waitrequest = 1'b0, m_readdatavalid = 1'b0;
    logic [DW-1:0]   m_readdata = '0;

    sdram_arbiter #(.AW(AW), .DW(DW), .LW(LW)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .we(we), .addr(addr), .wdata(wdata), .len(len),
        .grant(grant), .ack(ack), .rvalid(rvalid), .rdata(rdata), .done(done),
        .m_address(m_address), .m_read(m_read), .m_write(m_write), .m_writedata(m_writedata),
        .m_waitrequest(m_waitrequest), .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0, cyc = 0;
    // reference model: burst context as plain counts
    bit busy = 0, dn = 0, mwe = 0;
    int own = 0, mlen = 0, iss = 0, ret = 0, rr_last = 2;
    logic [AW-1:0] base = '0;
    // slave model
    int lat = 3;
    int due_q[$];
    logic [DW-1:0] dq[$];
    logic [DW-1:0] rd_next = '0;
    // observation logs
    logic [AW-1:0] acc_addr[$];
    logic [DW-1:0] rd_log[$], wd_log[$];
    int done_log[$], gnt_obs[$], gnt_cyc[$];
    int ack_cnt[3], rv_cnt[3];
    int done_cyc = 0, last_rv_cyc = 0, req_cyc = 0;
    logic [2:0] prev_grant = '0, done_seen = '0, ack_seen = '0, drop_mask = 3'b111;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int idx(input logic [2:0] v);
        return v[0] ? 0 : v[1] ? 1 : v[2] ? 2 : -1;
    endfunction

    function automatic logic [2:0] oh(input int i);
        return 3'(1 << i);
    endfunction

    task automatic check_model();
        logic [2:0] eg, ea, ev, ed;
        logic cmd;
        cyc++;
        if (!reset_n) begin
            busy = 0;
            dn = 0;
            rr_last = 2;
            chk("reset_outputs", {grant, ack, rvalid, done, m_read, m_write}, 0);
            chk("reset_address", m_address, 0);
        end else begin
            eg = '0; ea = '0; ev = '0; ed = '0; cmd = 1'b0;
            if (dn) begin
                eg = oh(own);
                ed = oh(own);
            end else if (busy) begin
                eg = oh(own);
                cmd = iss < mlen;
                ea = (cmd && mwe && !m_waitrequest) ? oh(own) : 3'b000;
                ev = m_readdatavalid ? oh(own) : 3'b000;
            end
            chk("grant", grant, eg);
            chk("ack", ack, ea);
            chk("rvalid", rvalid, ev);
            chk("done", done, ed);
            chk("m_read", m_read, cmd && !mwe);
            chk("m_write", m_write, cmd && mwe);
            if (cmd) chk("m_address", m_address, AW'(base + AW'(iss)));
            if (cmd && mwe) chk("m_writedata", m_writedata, wdata[own*DW +: DW]);
            if (|ev) chk("rdata", rdata, m_readdata);
            if (dn) begin
                dn = 0;
                if (own != 0) rr_last = own;
            end else if (busy) begin
                if (cmd && !m_waitrequest) iss++;
                if (m_readdatavalid && ret < mlen) ret++;
                if (iss == mlen && (mwe || ret == mlen)) begin
                    busy = 0;
                    dn = 1;
                end
            end else if (|req) begin
                own = req[0] ? 0 : (req[1] && req[2]) ? (rr_last == 1 ? 2 : 1) : req[1] ? 1 : 2;
                busy = 1;
                mwe = we[own];
                base = addr[own*AW +: AW];
                mlen = int'(len[own*LW +: LW]);
                if (mlen == 0) mlen = 1;
                iss = 0;
                ret = 0;
            end
        end
        if (m_read && !m_waitrequest) begin
            due_q.push_back(cyc + lat);
            dq.push_back(rd_next);
            rd_next = rd_next + DW'(1);
        end
        if ((m_read || m_write) && !m_waitrequest) acc_addr.push_back(m_address);
        if (|rvalid) begin
            rd_log.push_back(rdata);
            last_rv_cyc = cyc;
        end
        for (int i = 0; i < 3; i++) begin
            rv_cnt[i] += int'(rvalid[i]);
            ack_cnt[i] += int'(ack[i]);
        end
        if (|ack) wd_log.push_back(m_writedata);
        if (|done) begin
            done_log.push_back(idx(done));
            done_cyc = cyc;
        end
        if (|grant && grant != prev_grant) begin
            gnt_obs.push_back(idx(grant));
            gnt_cyc.push_back(cyc);
        end
        prev_grant = grant;
        done_seen = done;
        ack_seen = ack;
    endtask

    task automatic react();
        for (int i = 0; i < 3; i++) begin
            if (done_seen[i] && drop_mask[i]) req[i] = 1'b0;
            if (ack_seen[i]) wdata[i*DW +: DW] = wdata[i*DW +: DW] + DW'(1);
        end
        done_seen = '0;
        ack_seen = '0;
        if (due_q.size() > 0 && due_q[0] == cyc + 1) begin
            m_readdatavalid = 1'b1;
            m_readdata = dq[0];
            void'(due_q.pop_front());
            void'(dq.pop_front());
        end else begin
            m_readdatavalid = 1'b0;
            m_readdata = '0;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        check_model();
        @(posedge clk);
        #1;
        react();
    endtask

    task automatic wait_dones(input int n, input int budget, input string nm);
        int k = 0;
        while (done_log.size() < n && k < budget) begin
            cycle();
            k++;
        end
        chk(nm, done_log.size() >= n, 1);
    endtask

    task automatic clr();
        acc_addr.delete(); rd_log.delete(); wd_log.delete();
        done_log.delete(); gnt_obs.delete(); gnt_cyc.delete();
        for (int i = 0; i < 3; i++) begin
            ack_cnt[i] = 0;
            rv_cnt[i] = 0;
        end
    endtask

    task automatic set_port(input int p, input logic w, input logic [AW-1:0] a, input logic [LW-1:0] l, input logic [DW-1:0] d);
        we[p] = w;
        addr[p*AW +: AW] = a;
        len[p*LW +: LW] = l;
        wdata[p*DW +: DW] = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        @(posedge clk);
        #1;
        cycle();
        cycle();
        reset_n = 1'b1;
        cycle();

        // port 1 read burst, 3-cycle slave latency
        clr();
        lat = 3;
        rd_next = 16'hA0;
        set_port(1, 1'b0, 25'h100, 8'd4, 16'h0);
        req[1] = 1'b1;
        req_cyc = cyc + 1;
        wait_dones(1, 40, "t1_timeout");
        cycle();
        chk("t1_grant_latency", gnt_cyc[0] - req_cyc, 1);
        chk("t1_naddr", acc_addr.size(), 4);
        for (int i = 0; i < 4; i++) chk("t1_addr", acc_addr[i], 25'h100 + i);
        chk("t1_nrd", rd_log.size(), 4);
        for (int i = 0; i < 4; i++) chk("t1_rdata", rd_log[i], 16'hA0 + i);
        chk("t1_rv1", rv_cnt[1], 4);
        chk("t1_rv_other", rv_cnt[0] + rv_cnt[2], 0);
        chk("t1_done_port", done_log[0], 1);
        chk("t1_done_after_last", done_cyc - last_rv_cyc, 1);
        chk("t1_done_cycle", done_cyc - req_cyc, 8);

        // port 2 write burst with two waitrequest cycles
        clr();
        set_port(2, 1'b1, 25'h2000, 8'd3, 16'h5000);
        req[2] = 1'b1;
        req_cyc = cyc + 1;
        cycle();
        m_waitrequest = 1'b1;
        cycle();
        cycle();
        m_waitrequest = 1'b0;
        wait_dones(1, 20, "t2_timeout");
        cycle();
        chk("t2_acks", ack_cnt[2], 3);
        chk("t2_ack_other", ack_cnt[0] + ack_cnt[1], 0);
        for (int i = 0; i < 3; i++) chk("t2_wdata", wd_log[i], 16'h5000 + i);
        for (int i = 0; i < 3; i++) chk("t2_addr", acc_addr[i], 25'h2000 + i);
        chk("t2_done_cycle", done_cyc - req_cyc, 6);

        // all three request together, len 1 each
        clr();
        set_port(0, 1'b0, 25'h10, 8'd1, 16'h0);
        set_port(1, 1'b1, 25'h20, 8'd1, 16'h1111);
        set_port(2, 1'b0, 25'h30, 8'd1, 16'h0);
        req = 3'b111;
        wait_dones(3, 60, "t3_timeout");
        cycle();
        for (int i = 0; i < 3; i++) begin
            chk("t3_grant_order", gnt_obs[i], i);
            chk("t3_done_order", done_log[i], i);
        end

        // ports 1 and 2 continuous, port 0 joins mid-stream
        clr();
        drop_mask = 3'b001;
        set_port(0, 1'b1, 25'h50, 8'd1, 16'h0);
        set_port(1, 1'b1, 25'h60, 8'd2, 16'h0);
        set_port(2, 1'b1, 25'h70, 8'd2, 16'h0);
        req = 3'b110;
        wait_dones(3, 60, "t4_timeout_a");
        cycle();
        cycle();
        req[0] = 1'b1;
        wait_dones(6, 60, "t4_timeout_b");
        req = 3'b000;
        cycle();
        cycle();
        drop_mask = 3'b111;
        chk("t4_g0", gnt_obs[0], 1);
        chk("t4_g1", gnt_obs[1], 2);
        chk("t4_g2", gnt_obs[2], 1);
        chk("t4_g3", gnt_obs[3], 2);
        chk("t4_g4", gnt_obs[4], 0);
        chk("t4_g5", gnt_obs[5], 1);
        for (int i = 0; i < 3; i++) chk("t4_spacing", gnt_cyc[i+1] - gnt_cyc[i], 4);
        chk("t4_nbursts", gnt_obs.size(), 6);

        // reset during DRAIN of a len-8 read
        clr();
        lat = 10;
        rd_next = 16'hB0;
        set_port(1, 1'b0, 25'h300, 8'd8, 16'h0);
        req[1] = 1'b1;
        for (int k = 0; k < 60 && rv_cnt[1] < 3; k++) cycle();
        chk("t5_three_returns", rv_cnt[1], 3);
        chk("t5_in_drain", {m_read, grant}, 4'b0010);
        reset_n = 1'b0;
        req = 3'b000;
        #1;
        chk("t5_async_ctl", {grant, ack, rvalid, done, m_read, m_write}, 0);
        chk("t5_async_addr", m_address, 0);
        cycle();
        cycle();
        reset_n = 1'b1;
        for (int k = 0; k < 12; k++) cycle();
        chk("t5_no_stray_rvalid", rv_cnt[1] + rv_cnt[0] + rv_cnt[2], 3);
        chk("t5_no_done", done_log.size(), 0);
        lat = 3;
        rd_next = 16'hC0;
        set_port(2, 1'b0, 25'h400, 8'd2, 16'h0);
        req[2] = 1'b1;
        wait_dones(1, 30, "t5_timeout");
        cycle();
        chk("t5_fresh_done", done_log[0], 2);
        chk("t5_fresh_rd0", rd_log[3], 16'hC0);
        chk("t5_fresh_rd1", rd_log[4], 16'hC1);

        // address wrap with req dropped mid-burst, then len 0
        clr();
        rd_next = 16'hD0;
        set_port(0, 1'b0, 25'h1FFFFFE, 8'd4, 16'h0);
        req[0] = 1'b1;
        cycle();
        cycle();
        req[0] = 1'b0;
        wait_dones(1, 30, "t6_timeout_a");
        cycle();
        chk("t6_naddr", acc_addr.size(), 4);
        chk("t6_a0", acc_addr[0], 25'h1FFFFFE);
        chk("t6_a1", acc_addr[1], 25'h1FFFFFF);
        chk("t6_a2", acc_addr[2], 25'h0000000);
        chk("t6_a3", acc_addr[3], 25'h0000001);
        chk("t6_rv0", rv_cnt[0], 4);
        clr();
        set_port(1, 1'b1, 25'h77, 8'd0, 16'h9999);
        req[1] = 1'b1;
        wait_dones(1, 20, "t6_timeout_b");
        cycle();
        cycle();
        chk("t6_len0_acks", ack_cnt[1], 1);
        chk("t6_len0_naddr", acc_addr.size(), 1);
        chk("t6_len0_addr", acc_addr[0], 25'h77);
        chk("t6_len0_wdata", wd_log[0], 16'h9999);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Three-port arbiter that shares the single SDRAM controller slave in `soc` between the VGA line fetcher (port 0), the sprite blitter (port 1) and the CPU bridge (port 2). Port 0 has fixed top priority so scanout never starves. Ports 1 and 2 alternate round-robin. Each grant runs one burst of single-word Avalon-MM accesses at incrementing addresses, and read data is routed back to the owning requester.

## Interface
- AW, 25, word address width (64 MB / 16-bit words)
- DW, 16, data width
- LW, 8, burst length field width

- clk  in  1  system clock (50 MHz, same as `clk_clk`)
- reset_n  in  1  asynchronous, active-low reset
- req  in  3  per-port request; held high until the matching `done` pulse
- we  in  3  per-port direction: 1 = write, 0 = read
- addr  in  3*AW  per-port start word address (port i at [i*AW +: AW])
- wdata  in  3*DW  per-port current write word
- len  in  3*LW  per-port burst length in words; 0 is treated as 1
- grant  out  3  one-hot current owner; 0 when idle
- ack  out  3  write word accepted; the owner presents its next word in the following cycle
- rvalid  out  3  read word valid for the owner
- rdata  out  DW  read data, shared by all ports
- done  out  3  one-cycle pulse when the owner's burst completes
- m_address  out  AW  to SDRAM slave
- m_read, m_write  out  1  to SDRAM slave
- m_writedata  out  DW  to SDRAM slave
- m_waitrequest  in  1  from SDRAM slave
- m_readdata  in  DW  from SDRAM slave
- m_readdatavalid  in  1  from SDRAM slave

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE, no request: stay in IDLE.
- IDLE, any `req`: pick the winner.
  - `req[0]` wins if set.
  - Otherwise, if both `req[1]` and `req[2]` are set, the port not served last among {1,2} wins.
  - Otherwise the single requester wins.
  - Latch owner, `we`, `addr`, `len` (0 becomes 1). Clear issue count and return count. Go to ISSUE.
- ISSUE:
  - Assert `m_read` or `m_write` as selected by the latched `we`.
  - `m_address` = base + issue count, modulo 2^AW.
  - `m_writedata` = owner's `wdata` (combinational mux).
  - Each cycle with the command asserted and `m_waitrequest` low counts as accepted: the issue count increments, and for writes `ack[owner]` pulses that same cycle.
  - On the last accepted command: drop the command in the next cycle. A write goes to DONE; a read goes to DRAIN, or to DONE if every word has already returned.
- Read return, valid in ISSUE and DRAIN:
  - `rvalid[owner]` = `m_readdatavalid`; `rdata` = `m_readdata` (combinational).
  - The return count increments per valid word.
  - DRAIN exits to DONE once the return count equals `len`.
- DONE: pulse `done[owner]` for one cycle. Update the round-robin pointer if the owner was port 1 or 2. Clear `grant`. Go to IDLE.
- A new arbitration happens only from IDLE, so there is a minimum one-cycle gap between bursts.
- `req` is not sampled after grant. A requester dropping `req` mid-burst does not abort it; the burst completes.
- `m_readdatavalid` outside ISSUE/DRAIN is ignored: all `rvalid` stay 0.
- The return count saturates at `len`; extra returns are ignored.

## Timing
- Reset values:
  - `grant`, `ack`, `rvalid`, `done`, `m_read`, `m_write`: 0.
  - `m_address`: 0; `m_writedata`: don't-care.
  - State: IDLE; round-robin pointer favours port 1 next.
- Reset asserted mid-burst: everything returns to reset values immediately. The in-flight burst is abandoned; no `done` is issued.
- Latency: `req` high in IDLE in cycle N gives `grant` plus the first command in cycle N+1.
- Write burst of L words with no waitrequest: commands in N+1..N+L, `done` in N+L+1, IDLE in N+L+2.
- Read completion: `done` comes one cycle after the last `rvalid`.
- `m_address`, `m_read`, `m_write` and `grant` are registered. `ack`, `rvalid` and `rdata` are combinational from slave signals gated by registered state.
- Address wrap: base 2^AW-2 with len 4 issues 2^AW-2, 2^AW-1, 0, 1.

## Test plan
- Port 1 read, addr 0x100, len 4, slave returns 0xA0..0xA3 with 3-cycle latency -> 4 commands at 0x100..0x103; `rvalid[1]` x4 with data 0xA0..0xA3; `done[1]` one cycle after the last word; `rvalid[0]` and `rvalid[2]` stay 0.
- Port 2 write, len 3, `m_waitrequest` high on the first 2 cycles -> `m_write` held, `ack[2]` pulses exactly 3 times, `m_writedata` tracks port 2's `wdata`, `done[2]` next cycle.
- `req` = 3'b111 together, each len 1, held until done -> grant order 0, 1, 2; `done` pulses in that order.
- Ports 1 and 2 requesting continuously, len 2 -> grants alternate 1, 2, 1, 2 with a one-cycle IDLE gap between bursts; port 0 raised mid-stream wins the next arbitration.
- Reset asserted in DRAIN of a len-8 read after 3 returns -> all outputs 0 asynchronously; no `done`; stray `m_readdatavalid` after reset gives no `rvalid`; a fresh request is served normally.
- Port 0 read, addr 0x1FFFFFE, len 4 -> addresses 0x1FFFFFE, 0x1FFFFFF, 0x0000000, 0x0000001; `len` = 0 request -> exactly one access.
